// File: rtl/pgm_vram_arbiter.sv
// pgm_vram_arbiter
// Shares one single-port, synchronous-read 16-bit video RAM between the 68000
// bus and the tilemap renderer fetch port. The renderer normally wins. A
// starvation counter forces a CPU slot once a pending CPU access has lost
// CPU_MAX_WAIT consecutive cycles. The block also generates DTACK and the
// byte-lane write enables.
//
// Ports
//   fixed_20m_clk  system clock, rising edge
//   reset          synchronous, active-high
//   cpu_sel        VRAM selected with AS_n low, held until the bus cycle ends
//   cpu_rw_n       1 = read, 0 = write
//   cpu_uds_n      upper byte strobe, active low
//   cpu_lds_n      lower byte strobe, active low
//   cpu_addr       CPU word address
//   cpu_wdata      CPU write data
//   cpu_rdata      registered read data back to the CPU
//   cpu_dtack_n    registered DTACK, active low
//   ren_req        renderer fetch request
//   ren_addr       renderer word address
//   ren_ack        renderer granted this cycle (combinational)
//   ren_valid      ren_rdata holds data for the fetch acked two cycles earlier
//   ren_rdata      registered renderer read data
//   ram_addr       RAM address
//   ram_wdata      RAM write data (CPU write data passed through)
//   ram_we         RAM write enable
//   ram_be         byte enables {upper, lower}
//   ram_rdata      RAM read data, valid the cycle after the address
//
// CPU FSM
//   state  | meaning
//   IDLE   | no CPU access in progress; cpu_sel here is a new request
//   WAIT   | CPU request pending, lost arbitration at least once
//   ACCESS | RAM access issued last cycle; read data arrives now
//   DTACK  | DTACK asserted, waiting for the CPU to drop cpu_sel

module pgm_vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              fixed_20m_clk,
  input  logic              reset,
  input  logic              cpu_sel,
  input  logic              cpu_rw_n,
  input  logic              cpu_uds_n,
  input  logic              cpu_lds_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_dtack_n,
  input  logic              ren_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic              ren_ack,
  output logic              ren_valid,
  output logic [15:0]       ren_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic [1:0]        ram_be,
  input  logic [15:0]       ram_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DTACK  = 2'd3;

  localparam logic [3:0] STARVE_MAX = 4'(CPU_MAX_WAIT);

  logic [1:0] state;
  logic [3:0] starve;
  logic       ren_pend;   // renderer fetch issued last cycle, data on ram_rdata now
  logic       cpu_req;
  logic       cpu_grant;
  logic       ren_grant;

  // Reset gates both grants so nothing reaches the RAM in a reset cycle.
  always_comb begin
    cpu_req   = 1'b0;
    cpu_grant = 1'b0;
    ren_grant = 1'b0;
    if (!reset) begin
      cpu_req   = cpu_sel && ((state == ST_IDLE) || (state == ST_WAIT));
      cpu_grant = cpu_req && (!ren_req || (starve == STARVE_MAX));
      ren_grant = ren_req && !cpu_grant;
    end
  end

  assign ren_ack   = ren_grant;
  assign ram_addr  = cpu_grant ? cpu_addr : ren_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_grant && !cpu_rw_n && (!cpu_uds_n || !cpu_lds_n);
  assign ram_be    = {~cpu_uds_n, ~cpu_lds_n};

  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      starve      <= 4'd0;
      cpu_dtack_n <= 1'b1;
      cpu_rdata   <= 16'h0000;
      ren_pend    <= 1'b0;
      ren_valid   <= 1'b0;
      ren_rdata   <= 16'h0000;
    end else begin
      ren_pend  <= ren_grant;
      ren_valid <= ren_pend;
      if (ren_pend) begin
        ren_rdata <= ram_rdata;
      end

      case (state)
        ST_IDLE, ST_WAIT: begin
          if (!cpu_sel) begin
            // Bus cycle abandoned before it was served: no access, no DTACK.
            state  <= ST_IDLE;
            starve <= 4'd0;
          end else if (cpu_grant) begin
            state  <= ST_ACCESS;
            starve <= 4'd0;
          end else begin
            state <= ST_WAIT;
            if (starve != STARVE_MAX) begin
              starve <= starve + 4'd1;
            end
          end
        end
        ST_ACCESS: begin
          // The RAM access already happened; if the CPU has gone away the
          // write still lands but no DTACK is raised.
          if (!cpu_sel) begin
            state <= ST_IDLE;
          end else begin
            if (cpu_rw_n) begin
              cpu_rdata <= ram_rdata;
            end
            cpu_dtack_n <= 1'b0;
            state       <= ST_DTACK;
          end
        end
        ST_DTACK: begin
          if (!cpu_sel) begin
            cpu_dtack_n <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_vram_arbiter.sv
module tb_pgm_vram_arbiter;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_sel, cpu_rw_n, cpu_uds_n, cpu_lds_n;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic [15:0]   cpu_rdata;
  logic          cpu_dtack_n;
  logic          ren_req;
  logic [AW-1:0] ren_addr;
  logic          ren_ack, ren_valid;
  logic [15:0]   ren_rdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic          ram_we;
  logic [1:0]    ram_be;
  logic [15:0]   ram_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pgm_vram_arbiter #(.ADDR_W(AW), .CPU_MAX_WAIT(4)) dut (
    .fixed_20m_clk(clk),
    .reset        (reset),
    .cpu_sel      (cpu_sel),
    .cpu_rw_n     (cpu_rw_n),
    .cpu_uds_n    (cpu_uds_n),
    .cpu_lds_n    (cpu_lds_n),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_dtack_n  (cpu_dtack_n),
    .ren_req      (ren_req),
    .ren_addr     (ren_addr),
    .ren_ack      (ren_ack),
    .ren_valid    (ren_valid),
    .ren_rdata    (ren_rdata),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_be       (ram_be),
    .ram_rdata    (ram_rdata)
  );

  // Video RAM model: word i holds 16'hC000 | i, except a few seeded words.
  logic [15:0] mem [0:(1<<AW)-1];
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 16'hC000 | 16'(i);
      mem[13'h0123] <= 16'hBEEF;
      mem[13'h0010] <= 16'h5566;
    end else begin
      if (ram_we) begin
        if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
        if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst, sel, rw_n, uds_n, lds_n;
    logic [AW-1:0] addr;
    logic [15:0]   wd;
    logic          rreq;
    logic [AW-1:0] raddr;
    logic          e_ack, e_we;
    logic [1:0]    e_be;
    logic [AW-1:0] e_ra;
    logic          e_dt;
    logic [15:0]   e_rd;
    logic          e_val;
    logic [15:0]   e_rrd;
    logic [3:0]    mask;  // 1: ram_addr, 2: ram_be, 4: cpu_rdata, 8: ren_rdata
  } vec_t;

  function automatic vec_t mk(
      input logic rst, input logic sel, input logic rw_n, input logic uds_n, input logic lds_n,
      input logic [AW-1:0] addr, input logic [15:0] wd, input logic rreq, input logic [AW-1:0] raddr,
      input logic e_ack, input logic e_we, input logic [1:0] e_be, input logic [AW-1:0] e_ra,
      input logic e_dt, input logic [15:0] e_rd, input logic e_val, input logic [15:0] e_rrd,
      input logic [3:0] mask);
    vec_t v;
    v.rst = rst; v.sel = sel; v.rw_n = rw_n; v.uds_n = uds_n; v.lds_n = lds_n;
    v.addr = addr; v.wd = wd; v.rreq = rreq; v.raddr = raddr;
    v.e_ack = e_ack; v.e_we = e_we; v.e_be = e_be; v.e_ra = e_ra; v.e_dt = e_dt;
    v.e_rd = e_rd; v.e_val = e_val; v.e_rrd = e_rrd; v.mask = mask;
    return v;
  endfunction

  vec_t tbl [23];

  task automatic cpu_read_contended(input logic [AW-1:0] a, input int exp_acks, input logic [15:0] exp_d);
    int acks = 0;
    bit granted = 0;
    bit dt = 0;
    cpu_sel = 1; cpu_rw_n = 1; cpu_uds_n = 0; cpu_lds_n = 0; cpu_addr = a;
    ren_req = 1; ren_addr = 13'h0200;
    for (int c = 0; c < 12 && !granted; c++) begin
      @(negedge clk);
      if (ren_ack) acks++;
      else if (ram_addr == a) granted = 1;
      next_cycle();
    end
    chk("contended_grant_seen", 32'(granted), 32'd1);
    chk("contended_ack_count", 32'(acks), 32'(exp_acks));
    ren_req = 0;
    for (int c = 0; c < 6 && !dt; c++) begin
      @(negedge clk);
      if (!cpu_dtack_n) dt = 1;
      else next_cycle();
    end
    chk("contended_dtack_seen", 32'(dt), 32'd1);
    chk("contended_rdata", 32'(cpu_rdata), 32'(exp_d));
    next_cycle();
    cpu_sel = 0;
    @(negedge clk);
    chk("contended_dtack_hold", 32'(cpu_dtack_n), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("contended_dtack_release", 32'(cpu_dtack_n), 32'd1);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            rst sel rw u  l  addr      wd        rq raddr     ack we be     ra        dt rd        val rrd       mask
    tbl[0]  = mk(1, 1, 0, 0, 0, 13'h0040, 16'hFFFF, 1, 13'h0001, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 0, 16'h0000, 4'hC);
    tbl[1]  = mk(0, 1, 1, 0, 0, 13'h0123, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0123, 1, 16'h0000, 0, 16'h0000, 4'hD);
    tbl[2]  = mk(0, 1, 1, 0, 0, 13'h0123, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 0, 16'h0000, 4'h4);
    tbl[3]  = mk(0, 1, 1, 0, 0, 13'h0123, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 0, 16'hBEEF, 0, 16'h0000, 4'h4);
    tbl[4]  = mk(0, 1, 1, 0, 0, 13'h0123, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 0, 16'hBEEF, 0, 16'h0000, 4'h4);
    tbl[5]  = mk(0, 0, 1, 0, 0, 13'h0123, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 0, 16'hBEEF, 0, 16'h0000, 4'h4);
    tbl[6]  = mk(0, 0, 1, 0, 0, 13'h0123, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'hBEEF, 0, 16'h0000, 4'h4);
    tbl[7]  = mk(0, 1, 0, 0, 1, 13'h0010, 16'h12AB, 0, 13'h0000, 0, 1, 2'b10, 13'h0010, 1, 16'hBEEF, 0, 16'h0000, 4'h7);
    tbl[8]  = mk(0, 1, 0, 0, 1, 13'h0010, 16'h12AB, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 0, 16'h0000, 4'h0);
    tbl[9]  = mk(0, 1, 0, 0, 1, 13'h0010, 16'h12AB, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 0, 16'hBEEF, 0, 16'h0000, 4'h4);
    tbl[10] = mk(0, 0, 0, 0, 1, 13'h0010, 16'h12AB, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 0, 16'h0000, 0, 16'h0000, 4'h0);
    tbl[11] = mk(0, 0, 1, 1, 1, 13'h0000, 16'h0000, 1, 13'h0010, 1, 0, 2'b00, 13'h0010, 1, 16'h0000, 0, 16'h0000, 4'h1);
    tbl[12] = mk(0, 0, 1, 1, 1, 13'h0000, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 0, 16'h0000, 4'h0);
    tbl[13] = mk(0, 0, 1, 1, 1, 13'h0000, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 1, 16'h1266, 4'h8);
    tbl[14] = mk(0, 0, 1, 1, 1, 13'h0000, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 0, 16'h1266, 4'h8);
    tbl[15] = mk(0, 1, 0, 1, 1, 13'h0020, 16'hFFFF, 0, 13'h0000, 0, 0, 2'b00, 13'h0020, 1, 16'h0000, 0, 16'h0000, 4'h1);
    tbl[16] = mk(0, 1, 0, 1, 1, 13'h0020, 16'hFFFF, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 0, 16'h0000, 4'h0);
    tbl[17] = mk(0, 1, 0, 1, 1, 13'h0020, 16'hFFFF, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 0, 16'h0000, 0, 16'h0000, 4'h0);
    tbl[18] = mk(0, 0, 0, 1, 1, 13'h0020, 16'hFFFF, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 0, 16'h0000, 0, 16'h0000, 4'h0);
    tbl[19] = mk(0, 0, 0, 1, 1, 13'h0020, 16'hFFFF, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 0, 16'h0000, 4'h0);
    tbl[20] = mk(0, 0, 1, 1, 1, 13'h0000, 16'h0000, 1, 13'h0020, 1, 0, 2'b00, 13'h0020, 1, 16'h0000, 0, 16'h0000, 4'h1);
    tbl[21] = mk(0, 0, 1, 1, 1, 13'h0000, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 0, 16'h0000, 4'h0);
    tbl[22] = mk(0, 0, 1, 1, 1, 13'h0000, 16'h0000, 0, 13'h0000, 0, 0, 2'b00, 13'h0000, 1, 16'h0000, 1, 16'hC020, 4'h8);

    reset = 1; mem_init = 1;
    cpu_sel = 0; cpu_rw_n = 1; cpu_uds_n = 1; cpu_lds_n = 1;
    cpu_addr = '0; cpu_wdata = '0; ren_req = 0; ren_addr = '0;
    next_cycle();
    mem_init = 0;
    next_cycle();

    // Table: reset cycle, uncontended read, byte write with readback, strobe-less write.
    for (int i = 0; i < 23; i++) begin
      reset = tbl[i].rst; cpu_sel = tbl[i].sel; cpu_rw_n = tbl[i].rw_n;
      cpu_uds_n = tbl[i].uds_n; cpu_lds_n = tbl[i].lds_n; cpu_addr = tbl[i].addr;
      cpu_wdata = tbl[i].wd; ren_req = tbl[i].rreq; ren_addr = tbl[i].raddr;
      @(negedge clk);
      chk($sformatf("v%0d_ren_ack", i),   32'(ren_ack),     32'(tbl[i].e_ack));
      chk($sformatf("v%0d_ram_we", i),    32'(ram_we),      32'(tbl[i].e_we));
      chk($sformatf("v%0d_dtack_n", i),   32'(cpu_dtack_n), 32'(tbl[i].e_dt));
      chk($sformatf("v%0d_ren_valid", i), 32'(ren_valid),   32'(tbl[i].e_val));
      if (tbl[i].mask[0]) chk($sformatf("v%0d_ram_addr", i),  32'(ram_addr),  32'(tbl[i].e_ra));
      if (tbl[i].mask[1]) chk($sformatf("v%0d_ram_be", i),    32'(ram_be),    32'(tbl[i].e_be));
      if (tbl[i].mask[2]) chk($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(tbl[i].e_rd));
      if (tbl[i].mask[3]) chk($sformatf("v%0d_ren_rdata", i), 32'(ren_rdata), 32'(tbl[i].e_rrd));
      next_cycle();
    end

    // Starvation: renderer streams continuously while a CPU read of 0x0005 waits.
    cpu_sel = 1; cpu_rw_n = 1; cpu_uds_n = 0; cpu_lds_n = 0; cpu_addr = 13'h0005;
    for (int c = 0; c < 10; c++) begin
      ren_req = 1; ren_addr = 13'(16'h0100 + c);
      @(negedge clk);
      chk($sformatf("starve_c%0d_ack", c), 32'(ren_ack), (c == 4) ? 32'd0 : 32'd1);
      if (c == 4) chk("starve_cpu_addr", 32'(ram_addr), 32'h0005);
      if (c == 6) begin
        chk("starve_dtack", 32'(cpu_dtack_n), 32'd0);
        chk("starve_rdata", 32'(cpu_rdata), 32'hC005);
      end
      if (c >= 2) begin
        chk($sformatf("starve_c%0d_valid", c), 32'(ren_valid), (c == 6) ? 32'd0 : 32'd1);
        if (c != 6) chk($sformatf("starve_c%0d_rrd", c), 32'(ren_rdata), 32'(16'hC000 | 16'(16'h0100 + c - 2)));
      end
      next_cycle();
    end
    cpu_sel = 0; ren_req = 0;
    next_cycle();
    @(negedge clk);
    chk("starve_dtack_release", 32'(cpu_dtack_n), 32'd1);
    next_cycle(); next_cycle(); next_cycle();

    // Renderer stream of addresses 0..7 with no CPU traffic.
    for (int c = 0; c < 12; c++) begin
      ren_req = (c < 8); ren_addr = 13'(c);
      @(negedge clk);
      chk($sformatf("stream_c%0d_ack", c), 32'(ren_ack), (c < 8) ? 32'd1 : 32'd0);
      chk($sformatf("stream_c%0d_valid", c), 32'(ren_valid), (c >= 2 && c < 10) ? 32'd1 : 32'd0);
      if (c >= 2 && c < 10) chk($sformatf("stream_c%0d_rrd", c), 32'(ren_rdata), 32'(16'hC000 | 16'(c - 2)));
      next_cycle();
    end
    ren_req = 0;

    // CPU drops select in WAIT after two lost cycles.
    cpu_sel = 1; cpu_rw_n = 0; cpu_uds_n = 0; cpu_lds_n = 0; cpu_addr = 13'h0030; cpu_wdata = 16'h9999;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) cpu_sel = 0;
      ren_req = (c < 3); ren_addr = 13'h0200;
      @(negedge clk);
      chk($sformatf("abort_c%0d_we", c), 32'(ram_we), 32'd0);
      chk($sformatf("abort_c%0d_dtack", c), 32'(cpu_dtack_n), 32'd1);
      next_cycle();
    end
    // Starve counter must be back at zero: a full four losses before the grant.
    cpu_read_contended(13'h0030, 4, 16'hC030);

    // Reset lands in ACCESS of a write.
    cpu_sel = 1; cpu_rw_n = 0; cpu_uds_n = 0; cpu_lds_n = 0; cpu_addr = 13'h0040; cpu_wdata = 16'hDEAD;
    ren_req = 0;
    @(negedge clk);
    chk("rst_wr_we", 32'(ram_we), 32'd1);
    next_cycle();
    reset = 1; ren_req = 1; ren_addr = 13'h0300;
    @(negedge clk);
    chk("rst_cycle_we", 32'(ram_we), 32'd0);
    chk("rst_cycle_ack", 32'(ren_ack), 32'd0);
    next_cycle();
    reset = 0; cpu_sel = 0; ren_req = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_c%0d_dtack", c), 32'(cpu_dtack_n), 32'd1);
      chk($sformatf("post_rst_c%0d_valid", c), 32'(ren_valid), 32'd0);
      next_cycle();
    end
    cpu_read_contended(13'h0040, 4, 16'hDEAD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
